// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - execute-stage ALU, 1-cycle logic/arith, iterative shifts; optional ALU_EXEC_ROTATE_EN (op 111 = ROL, else PASS)
module alu_exec_seq #(
  parameter int WIDTH      = 8,
  parameter int SHAMT_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
`ifdef ALU_EXEC_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b111;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state;
  logic [WIDTH-1:0]      work;
  logic [SHAMT_BITS-1:0] cnt;
  logic [2:0]            op_q;

  logic                  is_shift;
  logic [SHAMT_BITS-1:0] amt;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_carry;
  logic [WIDTH:0]        sum;
  logic [WIDTH:0]        diff;
  logic [WIDTH-1:0]      shift_val;
  logic                  shift_out;

  assign amt  = op2[SHAMT_BITS-1:0];
  assign sum  = {1'b0, op1} + {1'b0, op2};
  assign diff = {1'b0, op1} - {1'b0, op2};

  // decode which ops take the iterative path
  always_comb begin
    is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL);
`ifdef ALU_EXEC_ROTATE_EN
    is_shift = is_shift || (alu_op == OP_ROL);
`endif
  end

  // single-cycle result; default covers PASS and zero-amount shifts (op1 unchanged, carry 0)
  always_comb begin
    alu_res   = op1;
    alu_carry = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = ~diff[WIDTH];
      end
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      default: alu_res = op1;
    endcase
  end

  // one-bit step of the latched shift op
  always_comb begin
    shift_val = {work[WIDTH-2:0], 1'b0};
    shift_out = work[WIDTH-1];
    case (op_q)
      OP_SRL: begin
        shift_val = {1'b0, work[WIDTH-1:1]};
        shift_out = work[0];
      end
`ifdef ALU_EXEC_ROTATE_EN
      OP_ROL: begin
        shift_val = {work[WIDTH-2:0], work[WIDTH-1]};
        shift_out = work[WIDTH-1];
      end
`endif
      default: begin
        shift_val = {work[WIDTH-2:0], 1'b0};
        shift_out = work[WIDTH-1];
      end
    endcase
  end

  // control FSM with registered result, flags and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      work       <= '0;
      cnt        <= '0;
      op_q       <= '0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_neg   <= 1'b0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            work     <= op1;
            op_q     <= alu_op;
            cnt      <= amt;
            if (is_shift && (amt != '0)) begin
              state <= SHIFT;
            end else begin
              result     <= alu_res;
              flag_zero  <= (alu_res == '0);
              flag_carry <= alu_carry;
              flag_neg   <= alu_res[WIDTH-1];
              out_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= shift_val;
          cnt  <= cnt - SHAMT_BITS'(1);
          if (cnt == SHAMT_BITS'(1)) begin
            result     <= shift_val;
            flag_zero  <= (shift_val == '0);
            flag_carry <= shift_out;
            flag_neg   <= shift_val[WIDTH-1];
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - randomized self-checking bench for alu_exec_seq against an arithmetic reference model
module tb_alu_exec_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_op;
  logic [7:0] op1;
  logic [7:0] op2;
  logic [7:0] result;
  logic       flag_zero;
  logic       flag_carry;
  logic       flag_neg;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  alu_exec_seq #(.WIDTH(8), .SHAMT_BITS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .op1        (op1),
    .op2        (op2),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_neg   (flag_neg),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // reference: plain integer arithmetic per op, latency in cycles from accept to out_valid
  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic c, output int lat);
    int amt;
    int s;
    amt = int'(b) % 8;
    lat = 1;
    c   = 1'b0;
    r   = a;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = s[7:0]; c = s[8]; end
      3'd1: begin s = int'(a) - int'(b); r = s[7:0]; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        s = int'(a) << amt; r = s[7:0]; c = (amt > 0) ? s[8] : 1'b0; lat = 1 + amt;
      end
      3'd6: begin
        s = int'(a) >> amt; r = s[7:0]; c = (amt > 0) ? a[amt-1] : 1'b0; lat = 1 + amt;
      end
      default: begin
`ifdef ALU_EXEC_ROTATE_EN
        s = (int'(a) << amt) | (int'(a) >> (8 - amt)); r = s[7:0];
        c = (amt > 0) ? r[0] : 1'b0; lat = 1 + amt;
`else
        r = a; c = 1'b0; lat = 1;
`endif
      end
    endcase
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic pre_ready, input int hold);
    logic [7:0] er;
    logic       ec;
    int         elat;
    int         lat;
    model(op, a, b, er, ec, elat);
    wait_ready();
    alu_op = op; op1 = a; op2 = b; in_valid = 1'b1; out_ready = pre_ready;
    @(negedge clk);
    in_valid = 1'b0;
    alu_op = 3'($urandom); op1 = 8'($urandom); op2 = 8'($urandom);
    check("in_ready_busy", in_ready, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, elat);
    check("out_valid", out_valid, 1'b1);
    check("result", result, er);
    check("carry", flag_carry, ec);
    check("zero", flag_zero, (er == 8'h00));
    check("neg", flag_neg, er[7]);
    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; alu_op = 3'($urandom); op1 = 8'($urandom); op2 = 8'($urandom);
        @(negedge clk);
        check("hold_result", result, er);
        check("hold_valid", out_valid, 1'b1);
        check("hold_in_ready", in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("drain_valid", out_valid, 1'b0);
    check("drain_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  // start an op, leave it mid-flight, then reset asynchronously between clock edges
  task automatic reset_mid(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int cycles);
    wait_ready();
    alu_op = op; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_flags", {flag_zero, flag_carry, flag_neg}, 3'b000);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 3'd0; op1 = 8'h00; op2 = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 8'h00);
    check("reset_flags", {flag_zero, flag_carry, flag_neg}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    reset_mid(3'd0, 8'h12, 8'h34, 0);
    reset_mid(3'd5, 8'hFF, 8'h07, 3);

    run_op(3'd0, 8'hF0, 8'h20, 1'b1, 0);
    run_op(3'd1, 8'h05, 8'h05, 1'b1, 0);
    run_op(3'd1, 8'h03, 8'h05, 1'b0, 1);
    run_op(3'd5, 8'h81, 8'h03, 1'b1, 0);
    run_op(3'd5, 8'h81, 8'h01, 1'b0, 0);
    run_op(3'd6, 8'h5A, 8'h08, 1'b0, 5);
    run_op(3'd6, 8'hA5, 8'h07, 1'b0, 2);
    run_op(3'd7, 8'h81, 8'h01, 1'b1, 0);
    run_op(3'd7, 8'hC3, 8'h07, 1'b0, 1);
    run_op(3'd2, 8'hF0, 8'h0F, 1'b1, 0);
    run_op(3'd3, 8'h00, 8'h00, 1'b0, 0);
    run_op(3'd4, 8'hAA, 8'h55, 1'b1, 0);

    for (int k = 0; k < 60; k++) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
